// File: rtl/pwm_led_pkg.sv
// rtl/pwm_led_pkg.sv - shared state encoding, register offsets and CTRL bit indices for pwm_led_bank
package pwm_led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] DUTY_BASE    = 8'h00;
  localparam logic [7:0] CTRL_OFF     = 8'h40;
  localparam logic [7:0] PRESCALE_OFF = 8'h44;
  localparam logic [7:0] STATUS_OFF   = 8'h48;
  localparam logic [7:0] TARGET_BASE  = 8'h80;
  localparam logic [7:0] STEP_OFF     = 8'hC0;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FREEZE_BIT = 1;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: duty shadow, compare, polarity flop
// Fade stepper present only when PWM_LED_BANK_FADE_EN is defined.
module pwm_channel
  import pwm_led_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             load,
  input  logic             wrap,
  input  logic             freeze,
  input  logic [PWM_W-1:0] cnt,
  input  logic [PWM_W:0]   duty,
`ifdef PWM_LED_BANK_FADE_EN
  input  logic [PWM_W:0]   target,
  input  logic [7:0]       step,
  output logic             settled,
`endif
  output logic             pwm_out
);

  localparam int SW = PWM_W + 1;

  logic [SW-1:0] shadow;
  logic [SW-1:0] wrap_value;
  logic          raw;

`ifdef PWM_LED_BANK_FADE_EN
  localparam int DW = (SW > 8) ? SW : 8;

  logic          up;
  logic [DW-1:0] diff;
  logic [DW-1:0] amt;

  // Clamp the step to the remaining distance so the shadow never overshoots.
  always_comb begin
    up   = (target >= shadow);
    diff = up ? DW'(target - shadow) : DW'(shadow - target);
    amt  = (DW'(step) < diff) ? DW'(step) : diff;
    if (step != 8'd0) begin
      wrap_value = up ? shadow + SW'(amt) : shadow - SW'(amt);
    end else begin
      wrap_value = duty;
    end
  end

  assign settled = (shadow == target);
`else
  assign wrap_value = duty;
`endif

  assign raw = active & ({1'b0, cnt} < shadow);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      pwm_out <= ACTIVE_LOW;
    end else begin
      if (load) begin
        shadow <= duty;
      end else if (wrap && !freeze) begin
        shadow <= wrap_value;
      end
      pwm_out <= raw ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/pwm_led_bank.sv
// rtl/pwm_led_bank.sv - memory-mapped PWM bank: bus decode, prescaler, period counter, FSM
// Optional TARGET/STEP fader enabled by defining PWM_LED_BANK_FADE_EN.
module pwm_led_bank
  import pwm_led_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PWM_W      = 8,
  parameter int PRE_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_wren,
  input  logic [7:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  state_t           state;
  logic [PWM_W:0]   duty [NUM_CH];
  logic             ctrl_en;
  logic             ctrl_freeze;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;

  logic        wr;
  logic        rd;
  logic [7:0]  word;
  logic        en_next;
  logic        counting;
  logic        tick;
  logic        wrap;
  logic        fading;
  logic [31:0] status_word;
  logic [31:0] rdata_next;
  logic        unused_bits;

  assign wr   = bus_sel & bus_wren;
  assign rd   = bus_sel & ~bus_wren;
  assign word = bus_addr & 8'hFC;

  // Truncated write bits and the ignored byte-lane bits feed nothing.
  assign unused_bits = ^{bus_wdata, bus_addr[1:0]};

  assign en_next  = (wr && word == CTRL_OFF) ? bus_wdata[CTRL_EN_BIT] : ctrl_en;
  assign counting = (state == RUN) || (state == DRAIN);
  assign tick     = counting && (pre_cnt == prescale);
  assign wrap     = tick && (pwm_cnt == '1);

`ifdef PWM_LED_BANK_FADE_EN
  logic [PWM_W:0]    target [NUM_CH];
  logic [7:0]        step;
  logic [NUM_CH-1:0] settled;

  assign fading = ~&settled;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) target[i] <= '0;
      step <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (word == TARGET_BASE + 8'(4 * i)) target[i] <= bus_wdata[PWM_W:0];
      end
      if (word == STEP_OFF) step <= bus_wdata[7:0];
    end
  end
`else
  assign fading = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
      ctrl_en     <= 1'b0;
      ctrl_freeze <= 1'b0;
      prescale    <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (word == DUTY_BASE + 8'(4 * i)) duty[i] <= bus_wdata[PWM_W:0];
      end
      if (word == CTRL_OFF) begin
        ctrl_en     <= bus_wdata[CTRL_EN_BIT];
        ctrl_freeze <= bus_wdata[CTRL_FREEZE_BIT];
      end
      if (word == PRESCALE_OFF) prescale <= bus_wdata[PRE_W-1:0];
    end
  end

  always_comb begin
    status_word              = '0;
    status_word[0]           = (state != IDLE);
    status_word[1]           = fading;
    status_word[PWM_W+8:8]   = {1'b0, pwm_cnt};
  end

  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (word == DUTY_BASE + 8'(4 * i)) rdata_next = 32'(duty[i]);
`ifdef PWM_LED_BANK_FADE_EN
      if (word == TARGET_BASE + 8'(4 * i)) rdata_next = 32'(target[i]);
`endif
    end
    if (word == CTRL_OFF)     rdata_next = {30'd0, ctrl_freeze, ctrl_en};
    if (word == PRESCALE_OFF) rdata_next = 32'(prescale);
    if (word == STATUS_OFF)   rdata_next = status_word;
`ifdef PWM_LED_BANK_FADE_EN
    if (word == STEP_OFF)     rdata_next = 32'(step);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_rdata <= '0;
    end else if (rd) begin
      bus_rdata <= rdata_next;
    end
  end

  // A prescale lowered below the live pre_cnt restarts the prescaler without a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      case (state)
        IDLE: begin
          pre_cnt <= '0;
          pwm_cnt <= '0;
          if (en_next) state <= ARM;
        end
        ARM: begin
          pre_cnt <= '0;
          pwm_cnt <= '0;
          state   <= RUN;
        end
        RUN, DRAIN: begin
          pre_cnt <= (pre_cnt >= prescale) ? '0 : pre_cnt + PRE_W'(1);
          if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
          if (state == RUN) begin
            if (!en_next) state <= DRAIN;
          end else if (en_next) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .active  (counting),
      .load    (state == ARM),
      .wrap    (wrap),
      .freeze  (ctrl_freeze),
      .cnt     (pwm_cnt),
      .duty    (duty[g]),
`ifdef PWM_LED_BANK_FADE_EN
      .target  (target[g]),
      .step    (step),
      .settled (settled[g]),
`endif
      .pwm_out (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_led_bank.sv
// tb/tb_pwm_led_bank.sv - directed self-checking bench for pwm_led_bank (default build)
module tb_pwm_led_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_wren = 1'b0;
  logic [7:0]  bus_addr = 8'h00;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic [3:0]  pwm_out;
  logic        period_tick;

  int n_checks = 0;
  int n_fail = 0;

  int         act [4];
  int         ticks;
  int         tick_pos;
  logic [3:0] first_out;
  logic [31:0] rd;

  pwm_led_bank dut (
    .clk         (clk),
    .reset       (reset),
    .bus_sel     (bus_sel),
    .bus_wren    (bus_wren),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_wren = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_wren = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  // Samples n consecutive negedges; optionally issues one write at sample wr_at.
  task automatic measure(input int n, input int wr_at, input logic [7:0] a, input logic [31:0] d);
    for (int c = 0; c < 4; c++) act[c] = 0;
    ticks = 0;
    tick_pos = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) first_out = pwm_out;
      for (int c = 0; c < 4; c++) if (pwm_out[c] == 1'b0) act[c]++;
      if (period_tick) begin ticks++; tick_pos = i; end
      if (i == wr_at) begin
        bus_sel = 1'b1; bus_wren = 1'b1; bus_addr = a; bus_wdata = d;
      end else begin
        bus_sel = 1'b0; bus_wren = 1'b0;
      end
    end
    bus_sel = 1'b0; bus_wren = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (period_tick) break;
    end
    check(tag, 32'(period_tick), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'hF);
    check("reset_rdata", bus_rdata, 32'h0);
    check("reset_tick", 32'(period_tick), 32'h0);
    reset = 1'b1;

    bus_read(8'h40, rd); check("rd_ctrl_reset", rd, 32'h0);
    bus_read(8'h00, rd); check("rd_duty0_reset", rd, 32'h0);
    bus_read(8'h48, rd); check("rd_status_reset", rd, 32'h0);

    measure(1000, -1, 8'h00, 32'h0);
    check("idle_ticks", 32'(ticks), 32'd0);
    check("idle_active", 32'(act[0] + act[1] + act[2] + act[3]), 32'd0);

    bus_write(8'h00, 32'd64);
    bus_write(8'h04, 32'd0);
    bus_write(8'h08, 32'd256);
    bus_write(8'h0C, 32'd255);
    bus_write(8'h40, 32'h1);
    @(negedge clk);
    check("arm_out", 32'(pwm_out), 32'hF);

    measure(256, -1, 8'h00, 32'h0);
    check("p1_first_out", 32'(first_out), 32'h2);
    check("p1_ch0", 32'(act[0]), 32'd64);
    check("p1_ch1", 32'(act[1]), 32'd0);
    check("p1_ch2", 32'(act[2]), 32'd256);
    check("p1_ch3", 32'(act[3]), 32'd255);
    check("p1_ticks", 32'(ticks), 32'd1);
    check("p1_tick_pos", 32'(tick_pos), 32'd255);

    measure(256, 50, 8'h00, 32'd128);
    check("p2_ch0_old_width", 32'(act[0]), 32'd64);
    check("p2_tick_pos", 32'(tick_pos), 32'd255);

    measure(256, 50, 8'h00, 32'd64);
    check("p3_ch0_new_width", 32'(act[0]), 32'd128);
    check("p3_ticks", 32'(ticks), 32'd1);

    measure(256, 50, 8'h40, 32'h3);
    check("p4_ch0", 32'(act[0]), 32'd64);

    measure(256, 50, 8'h00, 32'd128);
    check("p5_frozen_ch0", 32'(act[0]), 32'd64);
    check("p5_ticks", 32'(ticks), 32'd1);

    measure(256, -1, 8'h00, 32'h0);
    check("p6_frozen_ch0", 32'(act[0]), 32'd64);
    check("p6_ch3", 32'(act[3]), 32'd255);

    bus_read(8'h48, rd); check("status_running", rd & 32'h1, 32'h1);
    bus_read(8'h00, rd); check("rd_duty0", rd, 32'd128);
    bus_read(8'h40, rd); check("rd_ctrl_frozen", rd, 32'h3);

    bus_write(8'h40, 32'h1);
    bus_write(8'h00, 32'd64);
    bus_write(8'h44, 32'd3);
    wait_tick("sync_tick");

    measure(1024, -1, 8'h00, 32'h0);
    check("pre3_ch0", 32'(act[0]), 32'd256);
    check("pre3_ch3", 32'(act[3]), 32'd1020);
    check("pre3_ch2", 32'(act[2]), 32'd1024);
    check("pre3_tick_pos", 32'(tick_pos), 32'd1023);

    measure(1024, 400, 8'h40, 32'h0);
    check("drain_ch0", 32'(act[0]), 32'd256);
    check("drain_ch2", 32'(act[2]), 32'd1024);
    check("drain_tick_pos", 32'(tick_pos), 32'd1023);

    measure(64, -1, 8'h00, 32'h0);
    check("after_drain_first", 32'(first_out), 32'hF);
    check("after_drain_active", 32'(act[0] + act[1] + act[2] + act[3]), 32'd0);
    check("after_drain_ticks", 32'(ticks), 32'd0);
    bus_read(8'h48, rd); check("status_idle", rd, 32'h0);

    bus_write(8'h80, 32'h55);
    bus_read(8'h80, rd); check("unmapped_80", rd, 32'h0);
    bus_read(8'h4C, rd); check("unmapped_4c", rd, 32'h0);
    bus_read(8'hC0, rd); check("unmapped_c0", rd, 32'h0);
    bus_write(8'h44, 32'h0001_2345);
    bus_read(8'h44, rd); check("prescale_trunc", rd, 32'h2345);
    bus_write(8'h04, 32'hFFFF_FFFF);
    bus_read(8'h06, rd); check("duty1_trunc", rd, 32'h1FF);

    bus_write(8'h40, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    check("run_before_reset", 32'(pwm_out), 32'h0);
    #2 reset = 1'b0;
    #1 check("async_reset_out", 32'(pwm_out), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    measure(300, -1, 8'h00, 32'h0);
    check("post_reset_active", 32'(act[0] + act[1] + act[2] + act[3]), 32'd0);
    check("post_reset_ticks", 32'(ticks), 32'd0);
    bus_read(8'h40, rd); check("post_reset_ctrl", rd, 32'h0);
    bus_read(8'h04, rd); check("post_reset_duty1", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
